ycbcr_to_rgb: RTL and testbench

//  Inverse of the RGB->YCbCr front end. Converts BT.601 studio-range YCbCr 8-bit

---
 rtl/ycc_pkg.sv | 44 ++++
 rtl/ycbcr_to_rgb_if.sv | 32 +++
 rtl/ycc_pipe_ctl.sv | 35 +++
 rtl/ycbcr_to_rgb.sv | 143 ++++++++++++++
 tb/tb_ycbcr_to_rgb.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/ycc_pkg.sv
// Shared constants, pixel types and the output clamp for the YCbCr->RGB converter.
// BT.601 studio-range coefficients are scaled by 256 and applied as signed 20-bit products.
package ycc_pkg;

  localparam int PIX_W  = 8;
  localparam int USER_W = 2;

  localparam logic signed [19:0] K_Y   = 20'sd298;
  localparam logic signed [19:0] K_RCR = 20'sd409;
  localparam logic signed [19:0] K_GCB = 20'sd100;
  localparam logic signed [19:0] K_GCR = 20'sd208;
  localparam logic signed [19:0] K_BCB = 20'sd516;

  localparam logic signed [9:0]  Y_OFS = 10'sd16;
  localparam logic signed [9:0]  C_OFS = 10'sd128;
  localparam logic signed [19:0] RND   = 20'sd128;
  localparam int                 SHIFT = 8;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } ycc_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Clamp an already-descaled signed value into the 0..255 display range.
  function automatic logic [7:0] sat_u8(input logic signed [19:0] v);
    logic [7:0] res;
    if (v < 20'sd0) begin
      res = 8'd0;
    end else if (v > 20'sd255) begin
      res = 8'hFF;
    end else begin
      res = v[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/ycbcr_to_rgb_if.sv
// Pixel stream bundle for ycbcr_to_rgb: YCbCr input side and RGB output side,
// each with a valid/ready handshake and a sof/eol sideband tag.
interface ycbcr_to_rgb_if #(
  parameter int PIX_W  = 8,
  parameter int USER_W = 2
);

  logic              in_valid;
  logic              in_ready;
  logic [PIX_W-1:0]  in_y;
  logic [PIX_W-1:0]  in_cb;
  logic [PIX_W-1:0]  in_cr;
  logic [USER_W-1:0] in_user;

  logic              out_valid;
  logic              out_ready;
  logic [PIX_W-1:0]  out_r;
  logic [PIX_W-1:0]  out_g;
  logic [PIX_W-1:0]  out_b;
  logic [USER_W-1:0] out_user;

  modport slave (
    input  in_valid, in_y, in_cb, in_cr, in_user, out_ready,
    output in_ready, out_valid, out_r, out_g, out_b, out_user
  );

  modport master (
    output in_valid, in_y, in_cb, in_cr, in_user, out_ready,
    input  in_ready, out_valid, out_r, out_g, out_b, out_user
  );

endinterface

// File: rtl/ycc_pipe_ctl.sv
// Valid/stall control for an N-stage lock-step pipeline: the whole pipe advances
// together whenever the last stage is empty or being drained.
module ycc_pipe_ctl #(
  parameter int N = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic adv,
  output logic out_valid
);

  logic [N-1:0] vld_r;

  // Advance and accept decisions; in_ready is held low during reset.
  always_comb begin
    adv       = !vld_r[N-1] || out_ready;
    in_ready  = adv && !rst;
    out_valid = vld_r[N-1];
  end

  // Stage valid bits shift on advance; bubbles travel as zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= {N{1'b0}};
    end else if (adv) begin
      vld_r <= {vld_r[N-2:0], in_valid && in_ready};
    end else begin
      vld_r <= vld_r;
    end
  end

endmodule

// File: rtl/ycbcr_to_rgb.sv
// BT.601 studio-range YCbCr to full-range RGB, three pipeline stages
// (offset removal, coefficient sums, descale+clamp) with valid/ready backpressure.
module ycbcr_to_rgb
  import ycc_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int USER_W = 2
) (
  input  logic          clk,
  input  logic          rst,
  ycbcr_to_rgb_if.slave bus
);

  localparam int EXT_W = 10 - PIX_W;

  logic adv_s;

  ycc_pipe_ctl #(.N(3)) u_ctl (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .out_ready (bus.out_ready),
    .in_ready  (bus.in_ready),
    .adv       (adv_s),
    .out_valid (bus.out_valid)
  );

  ycc_t              pix_s;
  logic signed [9:0] yp_d_s;
  logic signed [9:0] cbp_d_s;
  logic signed [9:0] crp_d_s;

  // Stage 1 inputs: strip the studio-range offsets.
  always_comb begin
    pix_s.y  = bus.in_y;
    pix_s.cb = bus.in_cb;
    pix_s.cr = bus.in_cr;
    yp_d_s   = $signed({{EXT_W{1'b0}}, pix_s.y})  - Y_OFS;
    cbp_d_s  = $signed({{EXT_W{1'b0}}, pix_s.cb}) - C_OFS;
    crp_d_s  = $signed({{EXT_W{1'b0}}, pix_s.cr}) - C_OFS;
  end

  logic signed [9:0] s1_yp_r;
  logic signed [9:0] s1_cbp_r;
  logic signed [9:0] s1_crp_r;
  logic [USER_W-1:0] s1_user_r;

  // Stage 1 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_yp_r   <= 10'sd0;
      s1_cbp_r  <= 10'sd0;
      s1_crp_r  <= 10'sd0;
      s1_user_r <= {USER_W{1'b0}};
    end else if (adv_s) begin
      s1_yp_r   <= yp_d_s;
      s1_cbp_r  <= cbp_d_s;
      s1_crp_r  <= crp_d_s;
      s1_user_r <= bus.in_user;
    end else begin
      s1_yp_r   <= s1_yp_r;
      s1_cbp_r  <= s1_cbp_r;
      s1_crp_r  <= s1_crp_r;
      s1_user_r <= s1_user_r;
    end
  end

  logic signed [19:0] yp_w_s;
  logic signed [19:0] cbp_w_s;
  logic signed [19:0] crp_w_s;
  logic signed [19:0] yk_s;
  logic signed [19:0] r_sum_s;
  logic signed [19:0] g_sum_s;
  logic signed [19:0] b_sum_s;

  // Stage 2 inputs: x256 coefficient sums with rounding bias; 20 bits never overflow.
  always_comb begin
    yp_w_s  = {{10{s1_yp_r[9]}},  s1_yp_r};
    cbp_w_s = {{10{s1_cbp_r[9]}}, s1_cbp_r};
    crp_w_s = {{10{s1_crp_r[9]}}, s1_crp_r};
    yk_s    = yp_w_s * K_Y;
    r_sum_s = yk_s + (crp_w_s * K_RCR) + RND;
    g_sum_s = yk_s - (cbp_w_s * K_GCB) - (crp_w_s * K_GCR) + RND;
    b_sum_s = yk_s + (cbp_w_s * K_BCB) + RND;
  end

  logic signed [19:0] s2_r_r;
  logic signed [19:0] s2_g_r;
  logic signed [19:0] s2_b_r;
  logic [USER_W-1:0]  s2_user_r;

  // Stage 2 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_r_r    <= 20'sd0;
      s2_g_r    <= 20'sd0;
      s2_b_r    <= 20'sd0;
      s2_user_r <= {USER_W{1'b0}};
    end else if (adv_s) begin
      s2_r_r    <= r_sum_s;
      s2_g_r    <= g_sum_s;
      s2_b_r    <= b_sum_s;
      s2_user_r <= s1_user_r;
    end else begin
      s2_r_r    <= s2_r_r;
      s2_g_r    <= s2_g_r;
      s2_b_r    <= s2_b_r;
      s2_user_r <= s2_user_r;
    end
  end

  rgb_t rgb_d_s;

  // Stage 3 inputs: arithmetic descale then clamp to 0..255.
  always_comb begin
    rgb_d_s.r = sat_u8(s2_r_r >>> SHIFT);
    rgb_d_s.g = sat_u8(s2_g_r >>> SHIFT);
    rgb_d_s.b = sat_u8(s2_b_r >>> SHIFT);
  end

  rgb_t              out_pix_r;
  logic [USER_W-1:0] out_user_r;

  // Output registers; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_pix_r  <= 24'd0;
      out_user_r <= {USER_W{1'b0}};
    end else if (adv_s) begin
      out_pix_r  <= rgb_d_s;
      out_user_r <= s2_user_r;
    end else begin
      out_pix_r  <= out_pix_r;
      out_user_r <= out_user_r;
    end
  end

  assign bus.out_r    = out_pix_r.r;
  assign bus.out_g    = out_pix_r.g;
  assign bus.out_b    = out_pix_r.b;
  assign bus.out_user = out_user_r;

endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// Self-checking bench for ycbcr_to_rgb: directed colour points, random backpressured
// stream, reset during stall and full-rate throughput, all against an integer model.
module tb_ycbcr_to_rgb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ycbcr_to_rgb_if bus ();

  ycbcr_to_rgb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int held_word;
  bit stall_prev = 1'b0;
  int n_out;

  function automatic int clamp8(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  // Reference: BT.601 inverse with x256 integer coefficients, floor division, clamp.
  function automatic int model(input int y, input int cb, input int cr, input int user);
    int yp, cbp, crp, r, g, b;
    yp  = y - 16;
    cbp = cb - 128;
    crp = cr - 128;
    r = clamp8((298 * yp + 409 * crp + 128) >>> 8);
    g = clamp8((298 * yp - 100 * cbp - 208 * crp + 128) >>> 8);
    b = clamp8((298 * yp + 516 * cbp + 128) >>> 8);
    return (user << 24) | (r << 16) | (g << 8) | b;
  endfunction

  function automatic int dut_word();
    return int'({bus.out_user, bus.out_r, bus.out_g, bus.out_b});
  endfunction

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input int y, input int cb, input int cr, input int user);
    bus.in_valid = v;
    bus.in_y     = 8'(y);
    bus.in_cb    = 8'(cb);
    bus.in_cr    = 8'(cr);
    bus.in_user  = 2'(user);
  endtask

  // Observe handshakes for this cycle against the scoreboard, then move to the next negedge.
  task automatic observe();
    #1;
    if (stall_prev) check_val("stall_hold", dut_word(), held_word);
    if (bus.in_valid && bus.in_ready)
      exp_q.push_back(model(bus.in_y, bus.in_cb, bus.in_cr, bus.in_user));
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      if (exp_q.size() == 0) check_val("extra_pixel", exp_q.size(), 1);
      else check_val("stream_pixel", dut_word(), exp_q.pop_front());
    end
    stall_prev = bus.out_valid && !bus.out_ready;
    if (stall_prev) held_word = dut_word();
    step();
  endtask

  task automatic directed(input string tag, input int y, input int cb, input int cr,
                          input int er, input int eg, input int eb);
    int lat;
    drive(1'b1, y, cb, cr, 2);
    bus.out_ready = 1'b1;
    #1;
    check_val({tag, "_in_ready"}, int'(bus.in_ready), 1);
    step();
    drive(1'b0, 0, 0, 0, 0);
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      step();
      lat++;
    end
    check_val({tag, "_latency"}, lat, 3);
    check_val({tag, "_rgb"}, int'({bus.out_r, bus.out_g, bus.out_b}), (er << 16) | (eg << 8) | eb);
    check_val({tag, "_model"}, dut_word(), model(y, cb, cr, 2));
    step();
  endtask

  initial begin
    int sent, cyc, first, cnt;
    rst = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, 0, 0, 0, 0);
    step();
    step();
    check_val("rst_in_ready", int'(bus.in_ready), 0);
    check_val("rst_out_valid", int'(bus.out_valid), 0);
    check_val("rst_out_word", dut_word(), 0);
    rst = 1'b0;
    step();

    directed("black", 16, 128, 128, 0, 0, 0);
    directed("white", 235, 128, 128, 255, 255, 255);
    directed("red", 81, 90, 240, 255, 0, 0);
    directed("zero", 0, 0, 0, 0, 135, 0);
    directed("full", 255, 255, 255, 255, 125, 255);

    // Random stream with 50% output backpressure.
    n_out = 0;
    sent = 0;
    cyc = 0;
    while ((sent < 64 || n_out < 64) && cyc < 3000) begin
      drive((sent < 64) && ($urandom_range(3) != 0), $urandom_range(255),
            $urandom_range(255), $urandom_range(255), $urandom_range(3));
      bus.out_ready = $urandom_range(1) == 1;
      #1;
      if (bus.in_valid && bus.in_ready) sent++;
      observe();
      cyc++;
    end
    check_val("stream_out_count", n_out, 64);
    check_val("stream_q_empty", exp_q.size(), 0);

    // Fill the pipe under stall, then reset for one clock.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, $urandom_range(255), $urandom_range(255), $urandom_range(255), 1);
      observe();
    end
    check_val("fill_out_valid", int'(bus.out_valid), 1);
    rst = 1'b1;
    #1;
    check_val("midrst_in_ready", int'(bus.in_ready), 0);
    step();
    check_val("midrst_out_valid", int'(bus.out_valid), 0);
    check_val("midrst_out_word", dut_word(), 0);
    rst = 1'b0;
    drive(1'b0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    exp_q.delete();
    stall_prev = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) cnt++;
      step();
    end
    check_val("no_stale_after_rst", cnt, 0);

    // Full-rate streaming.
    n_out = 0;
    first = -1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      drive(1'b1, $urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(3));
      if (bus.out_valid && first < 0) first = c;
      observe();
    end
    check_val("tput_first_out", first, 3);
    check_val("tput_out_count", n_out, 97);
    drive(1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) observe();
    check_val("tput_total", n_out, 100);
    check_val("tput_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
